// File: rtl/wimax_block_interleaver.sv
// WiMAX block interleaver for a QPSK coded block (s = 1, second permutation is identity).
// Each serial input bit k is written to bank address m_k = (N_CBPS/16)*(k%16) + k/16.
// The previously filled bank is read out sequentially.
// Two banks ping-pong, so continuous 1 bit/cycle input produces gap-free output.
// Optional macro INTERLEAVER_BLOCK_CNT_EN adds a 16-bit output block counter (block_cnt).
module wimax_block_interleaver #(
  parameter int unsigned N_CBPS = 192,
  parameter int unsigned ADDR_W = 9
) (
  input  logic        clk_100mhz,
  input  logic        reset,
  input  logic        fec_out_valid,
  input  logic        data_in,
  output logic        interleaver_out_valid,
  output logic        data_out
`ifdef INTERLEAVER_BLOCK_CNT_EN
  ,
  output logic [15:0] block_cnt
`endif
);

  localparam int unsigned ROWS  = N_CBPS / 16;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CNT_W = $clog2(N_CBPS);

  localparam logic [CNT_W-1:0]  LastCnt   = CNT_W'(N_CBPS - 1);
  localparam logic [ROW_W-1:0]  LastRow   = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] Bank1Base = ADDR_W'(N_CBPS);
  localparam logic [ADDR_W-1:0] ColStep   = ADDR_W'(ROWS);

  localparam logic [0:0] RdIdle = 1'b0;
  localparam logic [0:0] RdRun  = 1'b1;

  // Buffer: bank0 at [0..N_CBPS-1], bank1 at [N_CBPS..2*N_CBPS-1]; no reset needed
  logic mem_q [2*N_CBPS];

  // Write pointer: col = k%16, row = k/16, col_base = ROWS*col kept as a running sum
  logic [CNT_W-1:0]  wr_cnt_q;
  logic [3:0]        col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] col_base_q;
  logic              wr_bank_q;

  // Read pointer and output registers; rd_state_q doubles as rd_active
  logic [0:0]        rd_state_q;
  logic              rd_bank_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic              data_out_q;
  logic              out_valid_q;

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              handoff;
  logic              rd_last;

  // Address generation and block handoff decode
  always_comb begin
    wr_addr = (wr_bank_q ? Bank1Base : '0) + col_base_q + ADDR_W'(row_q);
    rd_addr = (rd_bank_q ? Bank1Base : '0) + ADDR_W'(rd_cnt_q);
    handoff = fec_out_valid && (wr_cnt_q == LastCnt);
    rd_last = (rd_state_q == RdRun) && (rd_cnt_q == LastCnt);
  end

  // Buffer write of each valid input bit at its permuted address
  always_ff @(posedge clk_100mhz) begin
    if (fec_out_valid) begin
      mem_q[wr_addr] <= data_in;
    end
  end

  // Write pointer: row/col counters advance per valid bit, bank flips at block end
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      wr_cnt_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      col_base_q <= '0;
      wr_bank_q  <= 1'b0;
    end else if (fec_out_valid) begin
      if (handoff) begin
        wr_cnt_q   <= '0;
        col_q      <= '0;
        row_q      <= '0;
        col_base_q <= '0;
        wr_bank_q  <= ~wr_bank_q;
      end else begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
        if (col_q == 4'd15) begin
          col_q      <= '0;
          col_base_q <= '0;
          if (row_q != LastRow) begin
            row_q <= row_q + 1'b1;
          end
        end else begin
          col_q      <= col_q + 1'b1;
          col_base_q <= col_base_q + ColStep;
        end
      end
    end
  end

  // Read FSM: stream a filled bank out; a handoff always restarts on the new bank
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      rd_state_q  <= RdIdle;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      data_out_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (rd_state_q == RdRun) begin
        data_out_q  <= mem_q[rd_addr];
        out_valid_q <= 1'b1;
        if (rd_last) begin
          rd_state_q <= RdIdle;
          rd_cnt_q   <= '0;
        end else begin
          rd_cnt_q <= rd_cnt_q + 1'b1;
        end
      end else begin
        out_valid_q <= 1'b0;
      end
      // Handoff wins over end-of-read so back-to-back blocks stay contiguous
      if (handoff) begin
        rd_state_q <= RdRun;
        rd_cnt_q   <= '0;
        rd_bank_q  <= wr_bank_q;
      end
    end
  end

  assign data_out              = data_out_q;
  assign interleaver_out_valid = out_valid_q;

`ifdef INTERLEAVER_BLOCK_CNT_EN
  logic [15:0] block_cnt_q;

  // Count blocks on the edge that emits each block's last bit; wraps naturally
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      block_cnt_q <= '0;
    end else if (rd_last) begin
      block_cnt_q <= block_cnt_q + 16'd1;
    end
  end

  assign block_cnt = block_cnt_q;
`endif

endmodule
